// File: rtl/demux_1x32_capture_pkg.sv
// Shared widths and state encoding for the 1:32 serial capture block.
package demux_1x32_capture_pkg;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } cap_state_t;
endpackage

// File: rtl/demux1x8_en.sv
// 1:8 demux slice: one-hot write strobe plus the data bit routed to that lane.
module demux1x8_en (
  input  logic       din,
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] strobe,
  output logic [7:0] data
);
  assign strobe = en ? (8'd1 << sel) : 8'd0;
  assign data   = strobe & {8{din}};
endmodule

// File: rtl/demux_1x32_capture.sv
// Serial-to-parallel capture: addressed writes in IDLE, pointer-driven scan frames in FILL.
module demux_1x32_capture
  import demux_1x32_capture_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  sel,
  input  logic              start,
  input  logic              clear,
  output logic [WORD_W-1:0] q,
  output logic              frame_valid,
  output logic              busy,
  output logic [IDX_W-1:0]  ptr
);
  localparam logic [IDX_W-1:0] START_IDX = LSB_FIRST ? IDX_W'(0) : IDX_W'(WORD_W-1);
  localparam logic [IDX_W-1:0] TERM_IDX  = LSB_FIRST ? IDX_W'(WORD_W-1) : IDX_W'(0);

  cap_state_t        state;
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] strobe, data, we;

  assign in_ready    = (state != DONE);
  assign busy        = (state == FILL);
  assign frame_valid = (state == DONE);
  assign accept      = in_valid & in_ready;
  assign idx         = (state == FILL) ? ptr : sel;

  // idx[4:3] picks the byte slice, idx[2:0] the bit within it
  for (genvar g = 0; g < WORD_W/8; g++) begin : g_dmx
    demux1x8_en u_dmx (
      .din    (din),
      .sel    (idx[2:0]),
      .en     (idx[4:3] == 2'(g)),
      .strobe (strobe[8*g +: 8]),
      .data   (data[8*g +: 8])
    );
  end

  assign we = strobe & {WORD_W{accept}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= START_IDX;
      q     <= '0;
    end else if (clear) begin
      state <= IDLE;
      ptr   <= START_IDX;
      q     <= '0;
    end else begin
      q <= (q & ~we) | (data & we);
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          ptr   <= START_IDX;
        end
        // leave FILL on the terminal beat so ptr never steps past the end
        FILL: if (accept) begin
          if (ptr == TERM_IDX) state <= DONE;
          else                 ptr   <= LSB_FIRST ? ptr + IDX_W'(1) : ptr - IDX_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demux_1x32_capture.sv
// Scoreboarded bench: expected frames are queued at start time, a monitor checks them on frame_valid.
module tb_demux_1x32_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din, in_valid, start, clear;
  logic [4:0]  sel;
  logic        in_ready, frame_valid, busy;
  logic [31:0] q;
  logic [4:0]  ptr;
  logic        din1, in_valid1, start1, clear1;
  logic [4:0]  sel1;
  logic        in_ready1, frame_valid1, busy1;
  logic [31:0] q1;
  logic [4:0]  ptr1;

  always #5 clk = ~clk;

  demux_1x32_capture #(.LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .start(start), .clear(clear), .q(q), .frame_valid(frame_valid),
    .busy(busy), .ptr(ptr));

  demux_1x32_capture #(.LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sel(sel1), .start(start1), .clear(clear1), .q(q1), .frame_valid(frame_valid1),
    .busy(busy1), .ptr(ptr1));

  typedef struct {
    logic [31:0] q;
    int          cyc;
  } frame_t;

  frame_t exp0[$];
  frame_t exp1[$];
  frame_t e0, e1;
  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  // monitors: every frame_valid must match the head of its queue, in value and cycle
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      if (exp0.size() == 0) chk("dut0 unexpected frame_valid", 32'd1, 32'd0);
      else begin
        e0 = exp0.pop_front();
        chk("dut0 frame q", q, e0.q);
        chk("dut0 frame cycle", cyc, e0.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && frame_valid1) begin
      if (exp1.size() == 0) chk("dut1 unexpected frame_valid", 32'd1, 32'd0);
      else begin
        e1 = exp1.pop_front();
        chk("dut1 frame q", q1, e1.q);
        chk("dut1 frame cycle", cyc, e1.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit d, input logic [4:0] s, input bit st, input bit cl);
    in_valid = v; din = d; sel = s; start = st; clear = cl;
    tick();
  endtask

  task automatic drive1(input bit v, input bit d, input bit st, input bit cl);
    in_valid1 = v; din1 = d; start1 = st; clear1 = cl;
    tick();
  endtask

  initial begin : stim
    logic [31:0] w;
    int          nb;
    bit          v;
    bit          d;
    in_valid = 1'b0; din = 1'b0; sel = 5'd0; start = 1'b0; clear = 1'b0;
    in_valid1 = 1'b0; din1 = 1'b0; start1 = 1'b0; clear1 = 1'b0; sel1 = 5'd0;

    // reset values, sampled while rst_n is still low
    #12;
    chk("reset q", q, 32'h0);
    chk("reset ptr", 32'(ptr), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset frame_valid", 32'(frame_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset ptr msb-first", 32'(ptr1), 32'd31);
    @(negedge clk);
    rst_n = 1'b1;

    // addressed writes
    drive(1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("addressed q", q, 32'h8000_0020);

    // back-to-back scan frame; sel is junk and a stray start lands mid-frame
    w = 32'hA5C3_0F96;
    exp0.push_back('{w, cyc + 33});
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, w[i], 5'd7, (i == 10), 1'b0);
      if (i == 15) begin
        settle();
        chk("scan ptr mid-frame", 32'(ptr), 32'd16);
      end
    end
    settle();
    chk("done in_ready", 32'(in_ready), 32'd0);
    chk("done busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("beat during done ignored", q, w);
    chk("idle in_ready", 32'(in_ready), 32'd1);

    // clear, then the same word with every third cycle idle
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    settle();
    chk("clear q", q, 32'h0);
    exp0.push_back('{w, cyc + 48});
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    nb = 0;
    for (int k = 1; k <= 47; k++) begin
      v = (k % 3 != 0);
      d = v ? w[nb] : 1'b0;
      drive(v, d, 5'd0, 1'b0, 1'b0);
      if (v) nb++;
      settle();
      chk("gapped busy", 32'(busy), (nb < 32) ? 32'd1 : 32'd0);
      if (nb < 32) chk("gapped ptr", 32'(ptr), 32'(nb));
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // abort after 10 beats; the beat alongside clear is dropped
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    settle();
    chk("abort q", q, 32'h0);
    chk("abort ptr", 32'(ptr), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("abort q stays", q, 32'h0);

    // start coinciding with an addressed beat, then a scan from index 0
    exp0.push_back('{32'h0000_0002, cyc + 33});
    drive(1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    settle();
    chk("start+beat q", q, 32'h0000_0008);
    chk("start+beat ptr", 32'(ptr), 32'd0);
    chk("start+beat busy", 32'(busy), 32'd1);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    chk("scan after start+beat q", q, 32'h0000_000A);
    for (int i = 2; i < 32; i++) drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // MSB-first instance: 0x00000001, then 0x80000001 to show retention
    drive1(1'b0, 1'b0, 1'b0, 1'b1);
    w = 32'h0000_0001;
    exp1.push_back('{w, cyc + 33});
    drive1(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("msb start ptr", 32'(ptr1), 32'd31);
    for (int i = 31; i >= 0; i--) begin
      drive1(1'b1, w[i], 1'b0, 1'b0);
      if (i == 31) begin
        settle();
        chk("msb ptr after first beat", 32'(ptr1), 32'd30);
      end
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    w = 32'h8000_0001;
    exp1.push_back('{w, cyc + 33});
    drive1(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 31; i >= 0; i--) begin
      drive1(1'b1, w[i], 1'b0, 1'b0);
      if (i == 31) begin
        settle();
        chk("msb first beat lands in q[31]", q1, 32'h8000_0001);
      end
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a frame, away from any edge
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset q", q, 32'h0);
    chk("async reset ptr", 32'(ptr), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset frame_valid", 32'(frame_valid), 32'd0);
    chk("async reset in_ready", 32'(in_ready), 32'd1);
    chk("async reset q msb-first", q1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();

    chk("dut0 frames outstanding", 32'(exp0.size()), 32'd0);
    chk("dut1 frames outstanding", 32'(exp1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end
endmodule

// File: doc/demux_1x32_capture.md
# demux_1x32_capture

Serial-to-parallel capture block: the receive-side counterpart of the 32:1 bit-select multiplexer path. One data bit per accepted beat is routed through a 1:32 demultiplexer into a 32-bit holding register. Two routing modes:
- Addressed mode: the bit goes to the position given by `sel`.
- Scan mode: an internal pointer walks all 32 positions and flags a completed frame.

It sits at the far end of any link that serialises a 32-bit word one selected bit at a time.

## Interface
Parameters:
- `LSB_FIRST`, 1: scan order. 1 means the pointer runs 0→31; 0 means 31→0.

Ports:
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `din` in 1: serial data bit.
- `in_valid` in 1: `din` (and `sel` in addressed mode) is valid this cycle.
- `in_ready` out 1: block accepts a beat this cycle. A beat is taken when `in_valid & in_ready`.
- `sel` in 5: destination bit index in addressed mode; ignored in scan mode.
- `start` in 1: one-cycle pulse that begins a scan frame.
- `clear` in 1: synchronous abort and zero of the holding register.
- `q` out 32: holding register.
- `frame_valid` out 1: one-cycle pulse when a scan frame completes.
- `busy` out 1: high while a scan frame is in progress.
- `ptr` out 5: current scan pointer, for debug.

## Operation
- States: `IDLE`, `FILL`, `DONE`. Encoding is local to the block.
- **IDLE** (addressed mode):
  - `in_ready`=1.
  - An accepted beat writes `q[sel] <= din`; all other bits hold.
  - `start`=1 → `FILL`; `ptr` loads 0 (LSB_FIRST=1) or 31 (LSB_FIRST=0).
  - A beat arriving in the same cycle as `start` is handled as an addressed write. Scan beats begin the following cycle.
- **FILL** (scan mode):
  - `in_ready`=1 and `busy`=1; `sel` is ignored.
  - Each accepted beat writes `q[ptr] <= din`, then `ptr` steps by ±1.
  - Idle cycles (`in_valid`=0) hold `ptr`. There is no timeout.
  - The beat written at the terminal index (31, or 0 when LSB_FIRST=0) → `DONE`.
  - `start` is ignored in this state.
- **DONE**:
  - Lasts exactly one cycle.
  - `frame_valid`=1, `in_ready`=0, `busy`=0.
  - `in_valid` is ignored and no data is lost: the upstream sender sees `in_ready`=0.
  - Always → `IDLE`.
- **`clear`**:
  - Highest priority, in any state.
  - Next edge: `q` <= 0, `ptr` <= scan start index, state → `IDLE`, no `frame_valid`.
  - A beat in the same cycle is dropped.
- **Reset values**: `q`=0, `ptr`=0 (LSB_FIRST=1) or 31, state `IDLE`, `frame_valid`=0, `busy`=0. `in_ready` is combinational from state, so it reads 1 while in reset.
- **Retention**: `q` holds its contents across frames. A new frame overwrites each bit in turn; bits not yet overwritten keep their old values.
- **Pointer arithmetic**: `ptr` is 5-bit and never wraps. The state machine leaves `FILL` before any step past the terminal index.

## Timing
- Write latency: `q[i]` shows the new bit on the edge that accepts the beat, i.e. it is visible in the next cycle.
- `frame_valid` is high in the cycle immediately after the 32nd accepted scan beat. `q` is complete in that same cycle.
- Minimum frame time: 1 start cycle + 32 beats + 1 `DONE` cycle = 34 cycles start-to-start.
- `in_ready`, `busy` and `frame_valid` are decoded from state only. None has a combinational path from the inputs.
- `rst_n` deassertion is synchronised externally. The block carries no synchroniser.

## Structure
- Shared package holds:
  - `WORD_W`=32 and `IDX_W`=5.
  - The state enum `cap_state_t`.
- Natural sub-module: `demux1x8_en`.
  - Inputs: `din`, 3-bit `sel`, `en`. Output: 8-bit one-hot write strobe, all zero when `en`=0.
  - Four instances. Enables are decoded from `idx[4:3]`, where `idx` = `sel` in `IDLE` and `ptr` in `FILL`.
  - The top ANDs the concatenated strobes with the beat-accept condition to form per-bit write enables for `q`.

## Test plan
- **Reset/addressed write**: reset, then beats (`sel`=5,`din`=1) and (`sel`=31,`din`=1) → `q`=32'h8000_0020; `frame_valid` never rises.
- **Scan fill**: LSB_FIRST=1, `start`, then 32 back-to-back beats of the bits of 32'hA5C3_0F96, LSB first → `frame_valid` pulses exactly once, in cycle 33 after `start`; `q`=32'hA5C3_0F96 in that cycle; `in_ready`=0 for that one cycle.
- **Gapped beats**: same word with `in_valid` low on every third cycle → same final `q`; `ptr` holds during gaps; `busy` stays 1 until the 32nd beat.
- **MSB-first**: LSB_FIRST=0, frame of 32'h0000_0001 sent MSB first → first accepted beat lands in `q[31]`; final `q`=32'h0000_0001.
- **Abort**: `clear` after 10 scan beats → next cycle `q`=0, state `IDLE`, `ptr`=0; the cycle-11 beat is dropped; no `frame_valid`.
- **Corner cases**:
  - `start` in `FILL` is ignored.
  - `start` together with an addressed beat (`sel`=3,`din`=1) → `q[3]`=1, then the scan proceeds from index 0.
  - `rst_n` low mid-frame → outputs go to reset values immediately, without waiting for a clock edge.
